// File: rtl/serial_mag_comparator_pkg.sv
// rtl/serial_mag_comparator_pkg.sv - shared state and result encodings for the serial comparator
package serial_mag_comparator_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CMP  = 1'b1
    } state_t;

    // One-hot result: bit 0 = eq, bit 1 = gt, bit 2 = lt; RES_NONE only before the first completion.
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_EQ   = 3'b001,
        RES_GT   = 3'b010,
        RES_LT   = 3'b100
    } result_t;

    function automatic result_t digit_result(input logic d_gt, input logic d_lt);
        if (d_gt)
            return RES_GT;
        else if (d_lt)
            return RES_LT;
        else
            return RES_EQ;
    endfunction

endpackage

// File: rtl/serial_mag_comparator_digit_cmp.sv
// rtl/serial_mag_comparator_digit_cmp.sv - combinational magnitude compare of one digit
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    assign eq = (x == y);
    assign gt = (x > y);
    assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - digit-serial MSB-first magnitude comparator
module serial_mag_comparator
    import serial_mag_comparator_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    result_t          res;
    result_t          pend;
    result_t          cur;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sign_flip;
    logic             d_eq;
    logic             d_gt;
    logic             d_lt;

    // Flipping the operand MSB at capture turns two's-complement order into plain unsigned order.
    assign sign_flip = {is_signed, {(WIDTH-1){1'b0}}};

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .x  (sh_a[WIDTH-1 -: DIGIT]),
        .y  (sh_b[WIDTH-1 -: DIGIT]),
        .eq (d_eq),
        .gt (d_gt),
        .lt (d_lt)
    );

    always_comb begin
        cur = digit_result(d_gt, d_lt);
        if (d_eq)
            cur = RES_EQ;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            res   <= RES_NONE;
            pend  <= RES_NONE;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sh_a  <= a ^ sign_flip;
                        sh_b  <= b ^ sign_flip;
                        cnt   <= '0;
                        pend  <= RES_NONE;
                        state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt + 1'b1;
                        if (EARLY_EXIT && cur != RES_EQ) begin
                            res   <= cur;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if (cnt == LAST) begin
                            // Constant-time mode: the earliest latched difference wins over later digits.
                            res   <= (pend != RES_NONE) ? pend : cur;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end else if (pend == RES_NONE && cur != RES_EQ) begin
                            pend <= cur;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CMP);
    assign eq   = res[0];
    assign gt   = res[1];
    assign lt   = res[2];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - scoreboard bench for the serial magnitude comparator
module tb_serial_mag_comparator;

    localparam logic [2:0] R_EQ = 3'b001;
    localparam logic [2:0] R_GT = 3'b010;
    localparam logic [2:0] R_LT = 3'b100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, sgn;
    logic [15:0] a, b;
    logic        busy, done, eq, gt, lt;
    logic        ct_start, ct_abort, ct_sgn;
    logic [15:0] ct_a, ct_b;
    logic        ct_busy, ct_done, ct_eq, ct_gt, ct_lt;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] res;
        int         at;
        string      name;
    } exp_t;

    exp_t q_main[$];
    exp_t q_ct[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .is_signed(sgn),
        .a(a), .b(b), .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    serial_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1'b0)) dut_ct (
        .clk(clk), .rst_n(rst_n), .start(ct_start), .abort(ct_abort), .is_signed(ct_sgn),
        .a(ct_a), .b(ct_b), .busy(ct_busy), .done(ct_done), .eq(ct_eq), .gt(ct_gt), .lt(ct_lt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q_main.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL main unexpected done at edge %0d: got done=1, expected none", cyc);
            end else begin
                e = q_main.pop_front();
                check({e.name, " result"}, 32'({lt, gt, eq}), 32'(e.res));
                check({e.name, " done edge"}, cyc, e.at);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ct_done === 1'b1) begin
            if (q_ct.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ct unexpected done at edge %0d: got done=1, expected none", cyc);
            end else begin
                e = q_ct.pop_front();
                check({e.name, " result"}, 32'({ct_lt, ct_gt, ct_eq}), 32'(e.res));
                check({e.name, " done edge"}, cyc, e.at);
            end
        end
    end

    task automatic issue(input bit ct, input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         input logic [2:0] res, input int lat, input bit expect_done, input string name);
        exp_t e;
        if (ct) begin
            ct_a = va; ct_b = vb; ct_sgn = vs; ct_start = 1'b1;
        end else begin
            a = va; b = vb; sgn = vs; start = 1'b1;
        end
        @(posedge clk); #1;
        if (expect_done) begin
            e.res  = res;
            e.at   = cyc + lat;
            e.name = name;
            if (ct) q_ct.push_back(e);
            else    q_main.push_back(e);
        end
        if (ct) ct_start = 1'b0;
        else    start = 1'b0;
    endtask

    task automatic wait_drain(input bit ct, input string name);
        int n;
        n = 0;
        while ((ct ? q_ct.size() : q_main.size()) != 0 && n < 40) begin
            @(posedge clk); #2;
            n++;
        end
        if ((ct ? q_ct.size() : q_main.size()) != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got no done in 40 cycles, expected one", name);
            if (ct) q_ct.delete();
            else    q_main.delete();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sgn = 1'b0; a = '0; b = '0;
        ct_start = 1'b0; ct_abort = 1'b0; ct_sgn = 1'b0; ct_a = '0; ct_b = '0;
        #12;
        check("reset outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
        check("reset ct outputs", 32'({ct_busy, ct_done, ct_eq, ct_gt, ct_lt}), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        issue(0, 16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b1, "eq_1234");
        for (int i = 0; i < 4; i++) begin
            check("busy during compare", 32'(busy), 32'd1);
            @(posedge clk); #1;
        end
        check("busy after compare", 32'(busy), 32'd0);
        check("done pulse", 32'(done), 32'd1);
        wait_drain(0, "eq_1234");

        issue(0, 16'h8000, 16'h7FFF, 1'b0, R_GT, 1, 1'b1, "u_8000_7fff");  wait_drain(0, "u_8000_7fff");
        issue(0, 16'h8000, 16'h7FFF, 1'b1, R_LT, 1, 1'b1, "s_8000_7fff");  wait_drain(0, "s_8000_7fff");
        issue(0, 16'h1235, 16'h1234, 1'b0, R_GT, 4, 1'b1, "u_1235_1234");  wait_drain(0, "u_1235_1234");
        issue(0, 16'h0010, 16'h0100, 1'b0, R_LT, 2, 1'b1, "u_0010_0100");  wait_drain(0, "u_0010_0100");
        issue(0, 16'hFFFF, 16'h0001, 1'b1, R_LT, 1, 1'b1, "s_m1_p1");      wait_drain(0, "s_m1_p1");
        issue(0, 16'h7FFF, 16'h8000, 1'b1, R_GT, 1, 1'b1, "s_max_min");    wait_drain(0, "s_max_min");
        issue(0, 16'hFFFE, 16'hFFFF, 1'b1, R_LT, 4, 1'b1, "s_m2_m1");      wait_drain(0, "s_m2_m1");

        // Start while busy with other operands must be ignored; restart on the done cycle.
        issue(0, 16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b1, "busy_first");
        a = 16'hF000; b = 16'h0000; sgn = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 10 && done !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        check("done seen for restart", 32'(done), 32'd1);
        issue(0, 16'h0002, 16'h0003, 1'b0, R_LT, 4, 1'b1, "back_to_back");
        wait_drain(0, "back_to_back");

        // Abort in the second compare cycle: no done, previous LT held.
        issue(0, 16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b0, "abort_mid");
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        idle_cycles(6);
        check("abort holds result", 32'({lt, gt, eq}), 32'(R_LT));

        // Abort coincident with an early-exit completion wins.
        issue(0, 16'h8000, 16'h0000, 1'b0, R_GT, 1, 1'b0, "abort_prio");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort prio done", 32'({busy, done}), 32'd0);
        idle_cycles(4);
        check("abort prio result", 32'({lt, gt, eq}), 32'(R_LT));

        abort = 1'b1;
        issue(0, 16'h0005, 16'h0003, 1'b0, R_GT, 4, 1'b1, "abort_idle_start");
        abort = 1'b0;
        wait_drain(0, "abort_idle_start");

        // Reset mid-compare discards everything.
        issue(0, 16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b0, "reset_mid");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset mid outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        idle_cycles(8);
        check("after reset outputs", 32'({busy, done, eq, gt, lt}), 32'd0);
        @(negedge clk);
        issue(0, 16'hABCD, 16'hABCD, 1'b0, R_EQ, 4, 1'b1, "post_reset_eq");
        wait_drain(0, "post_reset_eq");

        issue(1, 16'hF000, 16'h0000, 1'b0, R_GT, 4, 1'b1, "ct_f000_0000"); wait_drain(1, "ct_f000_0000");
        issue(1, 16'h0F00, 16'h1000, 1'b0, R_LT, 4, 1'b1, "ct_0f00_1000"); wait_drain(1, "ct_0f00_1000");
        issue(1, 16'h1234, 16'h1234, 1'b0, R_EQ, 4, 1'b1, "ct_eq");        wait_drain(1, "ct_eq");
        issue(1, 16'h8000, 16'h7FFF, 1'b1, R_LT, 4, 1'b1, "ct_s_8000");    wait_drain(1, "ct_s_8000");

        idle_cycles(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
